// File: rtl/mc_state_sequencer.sv
// Multicycle-CPU phase sequencer: walks IF/ID/EXE/MEM/WB from the IR opcode/func and
// tracks halt, illegal-instruction, run gating, data-memory wait and perf counters.
module mc_state_sequencer #(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       func,
  input  logic             run_en,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE1 = 3'b110,
    S_EXE2 = 3'b101,
    S_EXE3 = 3'b010,
    S_MEM  = 3'b011,
    S_WB1  = 3'b111,
    S_WB2  = 3'b100
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t cur;
  state_t id_next;
  state_t nxt;
  logic   is_halt;
  logic   is_illegal;
  logic   retire;

  assign state = cur;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    id_next    = S_IF;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (OpCode)
      6'b000000: begin
        case (func)
          6'b100000, 6'b100010, 6'b100100,
          6'b100101, 6'b101010, 6'b000000: id_next = S_EXE1;
          6'b001000:                       id_next = S_IF;
          default:                         is_illegal = 1'b1;
        endcase
      end
      6'b000010, 6'b000011:                        id_next = S_IF;
      6'b000100, 6'b000101, 6'b000001:             id_next = S_EXE2;
      6'b100011, 6'b101011:                        id_next = S_EXE3;
      6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b001010:                        id_next = S_EXE1;
      OP_HALT:                                     is_halt = 1'b1;
      default:                                     is_illegal = 1'b1;
    endcase
  end

  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF:   nxt = S_ID;
      S_ID:   nxt = id_next;
      S_EXE1: nxt = S_WB1;
      S_WB1:  nxt = S_IF;
      S_EXE2: nxt = S_IF;
      S_EXE3: nxt = S_MEM;
      S_MEM: begin
        if (MEM_WAIT_EN && !mem_ready) nxt = S_MEM;
        else if (OpCode == OP_LW)      nxt = S_WB2;
        else                           nxt = S_IF;
      end
      S_WB2:  nxt = S_IF;
      default: nxt = S_IF;
    endcase
  end

  assign retire = (nxt == S_IF) && (cur != S_IF);

  // Registers update on the falling edge so the rising-edge datapath sees a stable state.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(negedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur        <= S_IF;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      instr_done <= 1'b0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else if (run_en) begin
      if (halted) begin
        instr_done <= 1'b0;
      end else begin
        cur        <= nxt;
        cycle_cnt  <= cycle_cnt + CNT_W'(1);
        instr_done <= retire;
        if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
        if (cur == S_ID && is_halt)    halted     <= 1'b1;
        if (cur == S_ID && is_illegal) illegal_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_state_sequencer.sv
// Directed bench for mc_state_sequencer; a second instance (3-bit counters, no MEM wait)
// covers MEM_WAIT_EN=0 and counter wrap.
module tb_mc_state_sequencer;

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE1 = 3'b110;
  localparam logic [2:0] S_EXE2 = 3'b101;
  localparam logic [2:0] S_EXE3 = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB1  = 3'b111;
  localparam logic [2:0] S_WB2  = 3'b100;

  logic        CLK;
  logic        Reset;
  logic [5:0]  OpCode;
  logic [5:0]  func;
  logic        run_en;
  logic        mem_ready;
  logic [2:0]  state;
  logic        halted;
  logic        illegal_op;
  logic        instr_done;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  logic [2:0]  nw_state;
  logic        nw_halted;
  logic        nw_illegal_op;
  logic        nw_instr_done;
  logic [2:0]  nw_cycle_cnt;
  logic [2:0]  nw_instr_cnt;

  int tests = 0;
  int fails = 0;

  mc_state_sequencer #(.CNT_W(32), .MEM_WAIT_EN(1'b1)) dut (
    .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .func(func), .run_en(run_en),
    .mem_ready(mem_ready), .state(state), .halted(halted), .illegal_op(illegal_op),
    .instr_done(instr_done), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  mc_state_sequencer #(.CNT_W(3), .MEM_WAIT_EN(1'b0)) dut_nw (
    .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .func(func), .run_en(run_en),
    .mem_ready(mem_ready), .state(nw_state), .halted(nw_halted), .illegal_op(nw_illegal_op),
    .instr_done(nw_instr_done), .cycle_cnt(nw_cycle_cnt), .instr_cnt(nw_instr_cnt)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  task automatic check(input bit ok, input string msg);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s", msg);
    end
  endtask

  // Inputs change and outputs are sampled on the rising edge, away from the active falling edge.
  task automatic test_reset();
    @(posedge CLK);
    Reset = 1'b0; run_en = 1'b1; mem_ready = 1'b1; OpCode = 6'b000000; func = 6'b100000;
    #1;
    check({state, halted, illegal_op, instr_done, cycle_cnt, instr_cnt} === '0,
          $sformatf("reset: state=%b halted=%b illegal=%b done=%b cyc=%0d ins=%0d, required all 0",
                    state, halted, illegal_op, instr_done, cycle_cnt, instr_cnt));
    @(posedge CLK);
    Reset = 1'b1;
  endtask

  task automatic test_add();
    logic [2:0] exp [5] = '{S_IF, S_ID, S_EXE1, S_WB1, S_IF};
    test_reset();
    OpCode = 6'b000000; func = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(posedge CLK);
      check(state === exp[i], $sformatf("add_state[%0d]: got %b required %b", i, state, exp[i]));
    end
    check(instr_cnt === 32'd1, $sformatf("add_instr_cnt: got %0d required 1", instr_cnt));
    check(cycle_cnt === 32'd4, $sformatf("add_cycle_cnt: got %0d required 4", cycle_cnt));
    check(instr_done === 1'b1, $sformatf("add_done: got %b required 1", instr_done));
    @(posedge CLK);
    check({state, instr_done} === {S_ID, 1'b0},
          $sformatf("add_done_pulse: got state=%b done=%b required state=001 done=0", state, instr_done));
  endtask

  task automatic test_lw_wait();
    logic [2:0] exp    [8] = '{S_IF, S_ID, S_EXE3, S_MEM, S_MEM, S_MEM, S_WB2, S_IF};
    logic [2:0] exp_nw [6] = '{S_IF, S_ID, S_EXE3, S_MEM, S_WB2, S_IF};
    test_reset();
    OpCode = 6'b100011; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(posedge CLK);
      check(state === exp[i], $sformatf("lw_state[%0d]: got %b required %b", i, state, exp[i]));
      if (i < 6)
        check(nw_state === exp_nw[i],
              $sformatf("lw_nowait_state[%0d]: got %b required %b", i, nw_state, exp_nw[i]));
      if (i == 5) begin
        check({nw_cycle_cnt, nw_instr_cnt} === {3'd5, 3'd1},
              $sformatf("lw_nowait_cnt: got cyc=%0d ins=%0d required cyc=5 ins=1", nw_cycle_cnt, nw_instr_cnt));
        mem_ready = 1'b1;
      end
    end
    check({cycle_cnt, instr_cnt} === {32'd7, 32'd1},
          $sformatf("lw_cnt: got cyc=%0d ins=%0d required cyc=7 ins=1", cycle_cnt, instr_cnt));
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp [10] = '{S_IF, S_ID, S_EXE2, S_IF, S_ID, S_EXE3, S_MEM, S_IF, S_ID, S_IF};
    test_reset();
    OpCode = 6'b000100;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(posedge CLK);
      check(state === exp[i], $sformatf("b2b_state[%0d]: got %b required %b", i, state, exp[i]));
      if (i == 3) OpCode = 6'b101011;
      if (i == 7) OpCode = 6'b000010;
    end
    check({cycle_cnt, instr_cnt} === {32'd9, 32'd3},
          $sformatf("b2b_cnt: got cyc=%0d ins=%0d required cyc=9 ins=3", cycle_cnt, instr_cnt));
    check({nw_cycle_cnt, nw_instr_cnt} === {3'd1, 3'd3},
          $sformatf("b2b_wrap_cnt: got cyc=%0d ins=%0d required cyc=1 ins=3", nw_cycle_cnt, nw_instr_cnt));
  endtask

  task automatic test_halt();
    logic [2:0] exp [3] = '{S_IF, S_ID, S_IF};
    test_reset();
    OpCode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(posedge CLK);
      check(state === exp[i], $sformatf("halt_state[%0d]: got %b required %b", i, state, exp[i]));
      if (i == 1)
        check(halted === 1'b0, $sformatf("halt_early: got %b required 0", halted));
    end
    check({halted, instr_done, illegal_op} === 3'b110,
          $sformatf("halt_flags: got halted=%b done=%b illegal=%b required 1 1 0", halted, instr_done, illegal_op));
    check({cycle_cnt, instr_cnt} === {32'd2, 32'd1},
          $sformatf("halt_cnt: got cyc=%0d ins=%0d required cyc=2 ins=1", cycle_cnt, instr_cnt));
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      check({state, halted, instr_done} === {S_IF, 1'b1, 1'b0},
            $sformatf("halt_hold[%0d]: got state=%b halted=%b done=%b required 000 1 0", i, state, halted, instr_done));
    end
    check({cycle_cnt, instr_cnt} === {32'd2, 32'd1},
          $sformatf("halt_frozen_cnt: got cyc=%0d ins=%0d required cyc=2 ins=1", cycle_cnt, instr_cnt));
    test_reset();
  endtask

  task automatic test_illegal();
    logic [2:0] exp [3] = '{S_IF, S_ID, S_IF};
    test_reset();
    OpCode = 6'b111000;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(posedge CLK);
      check(state === exp[i], $sformatf("ill_state[%0d]: got %b required %b", i, state, exp[i]));
      if (i == 1)
        check(illegal_op === 1'b0, $sformatf("ill_early: got %b required 0", illegal_op));
    end
    check({illegal_op, instr_done, halted} === 3'b110,
          $sformatf("ill_flags: got illegal=%b done=%b halted=%b required 1 1 0", illegal_op, instr_done, halted));
    OpCode = 6'b000000; func = 6'b000111;
    @(posedge CLK);
    @(posedge CLK);
    check({state, illegal_op, instr_cnt} === {S_IF, 1'b1, 32'd2},
          $sformatf("ill_rfunc: got state=%b illegal=%b ins=%0d required 000 1 2", state, illegal_op, instr_cnt));
    OpCode = 6'b000010;
    @(posedge CLK);
    @(posedge CLK);
    check({state, illegal_op, instr_cnt} === {S_IF, 1'b1, 32'd3},
          $sformatf("ill_sticky: got state=%b illegal=%b ins=%0d required 000 1 3", state, illegal_op, instr_cnt));
  endtask

  task automatic test_run_en_and_abort();
    logic [2:0] exp [3] = '{S_IF, S_ID, S_EXE1};
    test_reset();
    OpCode = 6'b000000; func = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(posedge CLK);
      check(state === exp[i], $sformatf("run_state[%0d]: got %b required %b", i, state, exp[i]));
    end
    run_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      check({state, cycle_cnt} === {S_EXE1, 32'd2},
            $sformatf("run_hold[%0d]: got state=%b cyc=%0d required 110 2", i, state, cycle_cnt));
    end
    run_en = 1'b1;
    @(posedge CLK);
    check(state === S_WB1, $sformatf("run_resume: got %b required 111", state));
    @(posedge CLK);
    check({state, instr_done, cycle_cnt, instr_cnt} === {S_IF, 1'b1, 32'd4, 32'd1},
          $sformatf("run_retire: got state=%b done=%b cyc=%0d ins=%0d required 000 1 4 1",
                    state, instr_done, cycle_cnt, instr_cnt));
    run_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      check({state, instr_done} === {S_IF, 1'b1},
            $sformatf("run_done_hold[%0d]: got state=%b done=%b required 000 1", i, state, instr_done));
    end
    run_en = 1'b1; OpCode = 6'b100011; mem_ready = 1'b0;
    repeat (3) @(posedge CLK);
    check(state === S_MEM, $sformatf("abort_pre: got %b required 011", state));
    Reset = 1'b0;
    #1;
    check({state, halted, illegal_op, instr_done, cycle_cnt, instr_cnt} === '0,
          $sformatf("abort_reset: state=%b halted=%b illegal=%b done=%b cyc=%0d ins=%0d, required all 0",
                    state, halted, illegal_op, instr_done, cycle_cnt, instr_cnt));
    @(posedge CLK);
    Reset = 1'b1; mem_ready = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; run_en = 1'b1; mem_ready = 1'b1; OpCode = '0; func = '0;
    test_add();
    test_lw_wait();
    test_back_to_back();
    test_halt();
    test_illegal();
    test_run_en_and_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
